// File: rtl/scoreboard_pkg.sv
// Shared sizing and types for the register-hazard scoreboard.
package scoreboard_pkg;

    localparam int NUM_REGS = 10;
    localparam int IDX_W    = 4;
    localparam int CNT_W    = 2;

    typedef logic [CNT_W-1:0] cnt_t;

    // Register 0 reads as zero and is never tracked.
    localparam logic [IDX_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/scoreboard_entry.sv
// One register's outstanding-write counter: saturates at max, floors at 0.
module scoreboard_entry
    import scoreboard_pkg::*;
#(
    parameter int CNT_W = scoreboard_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             full
);

    logic [CNT_W-1:0] count_q, count_d;

    assign count   = count_q;
    assign nonzero = |count_q;
    assign full    = &count_q;

    // Next count: flush wins; simultaneous inc and dec cancel out.
    always_comb begin
        count_d = count_q;
        if (flush)
            count_d = '0;
        else if (inc && !dec && !full)
            count_d = count_q + CNT_W'(1);
        else if (dec && !inc && nonzero)
            count_d = count_q - CNT_W'(1);
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

endmodule

// File: rtl/stall_scoreboard.sv
// Register-hazard scoreboard: decodes issue/writeback indices, tracks
// in-flight writes per register and raises stall on RAW or counter-full.
module stall_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int NUM_REGS = scoreboard_pkg::NUM_REGS,
    parameter int IDX_W    = scoreboard_pkg::IDX_W,
    parameter int CNT_W    = scoreboard_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic [IDX_W-1:0]    issue_rs,
    input  logic                issue_rs_used,
    input  logic [IDX_W-1:0]    issue_rt,
    input  logic                issue_rt_used,
    input  logic                issue_wr,
    input  logic [IDX_W-1:0]    issue_rd,
    input  logic                wb_valid,
    input  logic [IDX_W-1:0]    wb_rd,
    input  logic                flush,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending,
    output logic                err,
    output logic [15:0]         stall_cycles
);

    // One-hot selects only cover 1..NUM_REGS-1, so register 0 and
    // out-of-range indices never match anything.
    logic [NUM_REGS-1:0] rs_sel, rt_sel, rd_sel, wb_sel;
    logic [NUM_REGS-1:0] inc, dec, nonzero, full;
    logic                accept, wb_bad;
    logic                err_q, err_d;
    logic [15:0]         sc_q, sc_d;

    assign rs_sel[0]  = 1'b0;
    assign rt_sel[0]  = 1'b0;
    assign rd_sel[0]  = 1'b0;
    assign wb_sel[0]  = 1'b0;
    assign inc[0]     = 1'b0;
    assign dec[0]     = 1'b0;
    assign nonzero[0] = 1'b0;
    assign full[0]    = 1'b0;

    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_ent
        logic [CNT_W-1:0] cnt;

        assign rs_sel[gi] = (issue_rs == IDX_W'(gi));
        assign rt_sel[gi] = (issue_rt == IDX_W'(gi));
        assign rd_sel[gi] = (issue_rd == IDX_W'(gi));
        assign wb_sel[gi] = (wb_rd == IDX_W'(gi));
        assign inc[gi]    = accept & issue_wr & rd_sel[gi];
        // A retire on an idle register is legal only when a write to the
        // same register is accepted in the same cycle.
        assign dec[gi]    = wb_valid & wb_sel[gi] & ((cnt != '0) | inc[gi]);

        scoreboard_entry #(.CNT_W(CNT_W)) u_entry (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (inc[gi]),
            .dec     (dec[gi]),
            .flush   (flush),
            .count   (cnt),
            .nonzero (nonzero[gi]),
            .full    (full[gi])
        );
    end

    // Stall on RAW against an outstanding write, or when the destination
    // counter cannot take another write. Flush is deliberately not a term.
    always_comb begin
        stall = issue_valid & ((issue_rs_used & |(rs_sel & nonzero)) |
                               (issue_rt_used & |(rt_sel & nonzero)) |
                               (issue_wr      & |(rd_sel & full)));
    end

    assign accept       = issue_valid & ~stall;
    assign wb_bad       = wb_valid & ~|dec;
    assign pending      = nonzero;
    assign err          = err_q;
    assign stall_cycles = sc_q;

    // Sticky error and saturating stall counter next state.
    always_comb begin
        err_d = err_q | wb_bad;
        sc_d  = sc_q;
        if (stall && sc_q != 16'hFFFF) sc_d = sc_q + 16'd1;
    end

    // Error flag and stall counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            sc_q  <= '0;
        end else begin
            err_q <= err_d;
            sc_q  <= sc_d;
        end
    end

endmodule

// File: tb/tb_stall_scoreboard.sv
// Directed bench: the driver queues per-cycle expectations, a monitor on the
// falling edge pops and compares them against the DUT outputs.
module tb_stall_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid, issue_rs_used, issue_rt_used, issue_wr;
    logic [3:0] issue_rs, issue_rt, issue_rd, wb_rd;
    logic       wb_valid, flush;
    logic       stall, err;
    logic [9:0] pending;
    logic [15:0] stall_cycles;

    typedef struct {
        string nm;
        int    s, p, e, c;   // -1 = don't check
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    stall_scoreboard dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_rs      (issue_rs),
        .issue_rs_used (issue_rs_used),
        .issue_rt      (issue_rt),
        .issue_rt_used (issue_rt_used),
        .issue_wr      (issue_wr),
        .issue_rd      (issue_rd),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .flush         (flush),
        .stall         (stall),
        .pending       (pending),
        .err           (err),
        .stall_cycles  (stall_cycles)
    );

    task automatic chk(input string nm, input string f, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s.%s: got %0d expected %0d", nm, f, act, exp);
    endtask

    // Monitor: compare one queued expectation per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.s >= 0) chk(e.nm, "stall", int'(stall), e.s);
                if (e.p >= 0) chk(e.nm, "pending", int'(pending), e.p);
                if (e.e >= 0) chk(e.nm, "err", int'(err), e.e);
                if (e.c >= 0) chk(e.nm, "stall_cycles", int'(stall_cycles), e.c);
            end
        end
    end

    // Drive one cycle's inputs just after the rising edge and queue what the
    // outputs must show during that cycle.
    task automatic cyc(input string nm, input int v, input int rs, input int rsu,
                       input int rt, input int rtu, input int wr, input int rd,
                       input int wbv, input int wbrd, input int fl,
                       input int es, input int ep, input int ee, input int ec);
        exp_t e;
        @(posedge clk); #1;
        issue_valid   = v[0];
        issue_rs      = 4'(rs);
        issue_rs_used = rsu[0];
        issue_rt      = 4'(rt);
        issue_rt_used = rtu[0];
        issue_wr      = wr[0];
        issue_rd      = 4'(rd);
        wb_valid      = wbv[0];
        wb_rd         = 4'(wbrd);
        flush         = fl[0];
        e.nm = nm; e.s = es; e.p = ep; e.e = ee; e.c = ec;
        q.push_back(e);
    endtask

    task automatic idle(input string nm, input int es, input int ep, input int ee, input int ec);
        cyc(nm, 0,0,0, 0,0, 0,0, 0,0, 0, es, ep, ee, ec);
    endtask

    initial begin
        rst_n = 1'b0;
        issue_valid = 0; issue_rs = 0; issue_rs_used = 0; issue_rt = 0; issue_rt_used = 0;
        issue_wr = 0; issue_rd = 0; wb_valid = 0; wb_rd = 0; flush = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        //            name       v rs u  rt u  wr rd wb r  fl   stall pend err sc
        idle("reset",                                           0,    0,   0,  0);
        // RAW on r3 released one cycle after writeback
        cyc("w3",      1, 0,0,  0,0,  1,3,  0,0,  0,            0,    0,   0,  0);
        cyc("r3a",     1, 3,1,  0,0,  0,0,  0,0,  0,            1,    8,   0,  0);
        cyc("r3b",     1, 3,1,  0,0,  0,0,  0,0,  0,            1,    8,   0,  1);
        cyc("r3wb",    1, 3,1,  0,0,  0,0,  1,3,  0,            1,    8,   0,  2);
        cyc("r3rel",   1, 3,1,  0,0,  0,0,  0,0,  0,            0,    0,   0,  3);
        // counter full on r5
        cyc("w5a",     1, 0,0,  0,0,  1,5,  0,0,  0,            0,    0,   0,  3);
        cyc("w5b",     1, 0,0,  0,0,  1,5,  0,0,  0,            0,   32,   0,  3);
        cyc("w5c",     1, 0,0,  0,0,  1,5,  0,0,  0,            0,   32,   0,  3);
        cyc("w5full",  1, 0,0,  0,0,  1,5,  0,0,  0,            1,   32,   0,  3);
        cyc("w5fwb",   1, 0,0,  0,0,  1,5,  1,5,  0,            1,   32,   0,  4);
        cyc("w5cnt2",  1, 0,0,  0,0,  1,5,  0,0,  0,            0,   32,   0,  5);
        cyc("d5a",     0, 0,0,  0,0,  0,0,  1,5,  0,            0,   32,   0,  5);
        cyc("d5b",     0, 0,0,  0,0,  0,0,  1,5,  0,            0,   32,   0,  5);
        cyc("d5c",     0, 0,0,  0,0,  0,0,  1,5,  0,            0,   32,   0,  5);
        // flush beats wb; stall ignores flush
        cyc("w2",      1, 0,0,  0,0,  1,2,  0,0,  0,            0,    0,   0,  5);
        cyc("w4",      1, 0,0,  0,0,  1,4,  0,0,  0,            0,    4,   0,  5);
        cyc("w9",      1, 0,0,  0,0,  1,9,  0,0,  0,            0,   20,   0,  5);
        cyc("flush",   1, 2,1,  0,0,  0,0,  1,4,  1,            1,  532,   0,  5);
        idle("postfl",                                          0,    0,   0,  6);
        // simultaneous inc/dec on r6, at count 1 and at count 0
        cyc("w6",      1, 0,0,  0,0,  1,6,  0,0,  0,            0,    0,   0,  6);
        cyc("w6wb6",   1, 0,0,  0,0,  1,6,  1,6,  0,            0,   64,   0,  6);
        idle("keep6",                                           0,   64,   0,  6);
        cyc("d6",      0, 0,0,  0,0,  0,0,  1,6,  0,            0,   64,   0,  6);
        cyc("w6wb0",   1, 0,0,  0,0,  1,6,  1,6,  0,            0,    0,   0,  6);
        idle("zero6",                                           0,    0,   0,  6);
        // r0 and out-of-range never tracked / stalled; bad wb sets err
        cyc("r0w0",    1, 0,1, 12,1,  1,0,  0,0,  0,            0,    0,   0,  6);
        cyc("wb7bad",  1, 0,1, 12,1,  0,0,  1,7,  0,            0,    0,   0,  6);
        idle("errset",                                          0,    0,   1,  6);
        idle("errstk",                                          0,    0,   1,  6);
        // async reset during a stall
        cyc("w8",      1, 0,0,  0,0,  1,8,  0,0,  0,            0,    0,   1,  6);
        cyc("r8st",    1, 8,1,  0,0,  0,0,  0,0,  0,            1,  256,   1,  6);
        cyc("r8st2",   1, 8,1,  0,0,  0,0,  0,0,  0,            1,  256,   1,  7);
        cyc("rstmid",  1, 8,1,  0,0,  0,0,  0,0,  0,            0,    0,   0,  0);
        #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
        cyc("r8post",  1, 8,1,  0,0,  0,0,  0,0,  0,            0,    0,   0,  0);
        cyc("wb12bad", 0, 0,0,  0,0,  0,0,  1,12, 0,            0,    0,   0,  0);
        idle("err12",                                           0,    0,   1,  0);
        cyc("wb0bad",  0, 0,0,  0,0,  0,0,  1,0,  0,            0,    0,   1,  0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk); #1;
        if (q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: got %0d queued expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
